// File: rtl/periph_error_slave.sv
// Error sink for the peripheral crossbar: grants every request and answers with a poisoned error response.
// Optional first-fault capture is built when PERIPH_ERR_CAPTURE_EN is defined.
module periph_error_slave #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BE_WIDTH     = 4,
  parameter int unsigned ID_WIDTH     = 9,
  parameter int unsigned RESP_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5),
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic                  r_opc_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [ID_WIDTH-1:0]   err_id_o,
  output logic                  err_we_o
);

  logic                vld_q [RESP_LATENCY];
  logic [ID_WIDTH-1:0] id_q  [RESP_LATENCY];
  logic [CNT_WIDTH-1:0] cnt_q;

  assign gnt_o = req_i;

  // Idle slots carry a zero ID so r_id_o reads 0 whenever no response is presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        id_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= req_i;
      id_q[0]  <= req_i ? id_i : '0;
      for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign r_valid_o = vld_q[RESP_LATENCY-1];
  assign r_id_o    = id_q[RESP_LATENCY-1];
  assign r_opc_o   = r_valid_o;
  assign r_rdata_o = r_valid_o ? ERR_RDATA : '0;

  // A clear coinciding with a request restarts the count at that request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= req_i ? CNT_WIDTH'(1) : '0;
    end else if (req_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign err_count_o = cnt_q;

`ifdef PERIPH_ERR_CAPTURE_EN
  logic                  cap_valid_q;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [ID_WIDTH-1:0]   cap_id_q;
  logic                  cap_we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_id_q    <= '0;
      cap_we_q    <= 1'b0;
    end else if (req_i && (clr_i || !cap_valid_q)) begin
      cap_valid_q <= 1'b1;
      cap_addr_q  <= add_i;
      cap_id_q    <= id_i;
      cap_we_q    <= ~wen_i;
    end else if (clr_i) begin
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_id_q    <= '0;
      cap_we_q    <= 1'b0;
    end
  end

  assign err_valid_o = cap_valid_q;
  assign err_addr_o  = cap_addr_q;
  assign err_id_o    = cap_id_q;
  assign err_we_o    = cap_we_q;

  logic unused_inputs;
  assign unused_inputs = ^{wdata_i, be_i};
`else
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_id_o    = '0;
  assign err_we_o    = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{wdata_i, be_i, add_i, wen_i};
`endif

endmodule

// File: tb/tb_periph_error_slave.sv
// Bench for periph_error_slave: two instances (latency 1 / 4-bit counter, latency 3 / 16-bit counter)
// share one request bus; a scoreboard per instance tracks expected responses.
module tb_periph_error_slave;

  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '1;
  logic [8:0]  id = '0;
  logic        clr = 1'b0;

  logic        gnt_a, rv_a, opc_a, ev_a, ew_a;
  logic [8:0]  rid_a, ei_a;
  logic [31:0] rdata_a, ea_a;
  logic [3:0]  cnt_a;
  logic        gnt_b, rv_b, opc_b, ev_b, ew_b;
  logic [8:0]  rid_b, ei_b;
  logic [31:0] rdata_b, ea_b;
  logic [15:0] cnt_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct { int unsigned due; logic [8:0] id; } rsp_t;
  rsp_t sb_a[$];
  rsp_t sb_b[$];

  periph_error_slave #(.RESP_LATENCY(1), .CNT_WIDTH(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .id_i(id), .gnt_o(gnt_a), .r_valid_o(rv_a), .r_opc_o(opc_a), .r_id_o(rid_a),
    .r_rdata_o(rdata_a), .clr_i(clr), .err_count_o(cnt_a), .err_valid_o(ev_a),
    .err_addr_o(ea_a), .err_id_o(ei_a), .err_we_o(ew_a));

  periph_error_slave #(.RESP_LATENCY(3), .CNT_WIDTH(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .id_i(id), .gnt_o(gnt_b), .r_valid_o(rv_b), .r_opc_o(opc_b), .r_id_o(rid_b),
    .r_rdata_o(rdata_b), .clr_i(clr), .err_count_o(cnt_b), .err_valid_o(ev_b),
    .err_addr_o(ea_b), .err_id_o(ei_b), .err_we_o(ew_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture outputs are only populated when the capture feature is compiled in.
  function automatic logic [42:0] exp_cap(input logic v, input logic [31:0] a,
                                          input logic [8:0] i, input logic w);
`ifdef PERIPH_ERR_CAPTURE_EN
    return {v, a, i, w};
`else
    return '0;
`endif
  endfunction

  // Response monitor: pops each scoreboard entry in the cycle it falls due.
  always @(negedge clk) begin
    if (rst_n) begin
      logic        xv;
      logic [8:0]  xid;
      xv  = (sb_a.size() > 0) && (sb_a[0].due == cyc);
      xid = xv ? sb_a[0].id : 9'h0;
      checks += 4;
      if (rv_a !== xv) begin errors++; $display("FAIL rsp_valid_a cyc=%0d got=%b exp=%b", cyc, rv_a, xv); end
      if (opc_a !== xv) begin errors++; $display("FAIL rsp_opc_a cyc=%0d got=%b exp=%b", cyc, opc_a, xv); end
      if (rid_a !== xid) begin errors++; $display("FAIL rsp_id_a cyc=%0d got=%h exp=%h", cyc, rid_a, xid); end
      if (rdata_a !== (xv ? ERR : 32'h0)) begin
        errors++; $display("FAIL rsp_rdata_a cyc=%0d got=%h exp=%h", cyc, rdata_a, xv ? ERR : 32'h0);
      end
      if (xv) void'(sb_a.pop_front());

      xv  = (sb_b.size() > 0) && (sb_b[0].due == cyc);
      xid = xv ? sb_b[0].id : 9'h0;
      checks += 4;
      if (rv_b !== xv) begin errors++; $display("FAIL rsp_valid_b cyc=%0d got=%b exp=%b", cyc, rv_b, xv); end
      if (opc_b !== xv) begin errors++; $display("FAIL rsp_opc_b cyc=%0d got=%b exp=%b", cyc, opc_b, xv); end
      if (rid_b !== xid) begin errors++; $display("FAIL rsp_id_b cyc=%0d got=%h exp=%h", cyc, rid_b, xid); end
      if (rdata_b !== (xv ? ERR : 32'h0)) begin
        errors++; $display("FAIL rsp_rdata_b cyc=%0d got=%h exp=%h", cyc, rdata_b, xv ? ERR : 32'h0);
      end
      if (xv) void'(sb_b.pop_front());
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [31:0] a, input logic [8:0] i, input logic w, input logic c);
    req = 1'b1; add = a; id = i; wen = w; clr = c;
    wdata = $urandom; be = 4'($urandom);
    sb_a.push_back('{due: cyc + 1, id: i});
    sb_b.push_back('{due: cyc + 3, id: i});
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b11) begin errors++; $display("FAIL gnt got=%b exp=11", {gnt_a, gnt_b}); end
    @(posedge clk); #1;
    req = 1'b0; clr = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    checks += 2;
    if ({rv_a, opc_a, rid_a, rdata_a, cnt_a, ev_a, ea_a, ei_a, ew_a} !== '0) begin
      errors++; $display("FAIL reset_a got=%b%b %h %h %h %b %h %h %b exp=all0", rv_a, opc_a, rid_a, rdata_a, cnt_a, ev_a, ea_a, ei_a, ew_a);
    end
    if ({rv_b, opc_b, rid_b, rdata_b, cnt_b, ev_b, ea_b, ei_b, ew_b} !== '0) begin
      errors++; $display("FAIL reset_b got=%b%b %h %h %h %b %h %h %b exp=all0", rv_b, opc_b, rid_b, rdata_b, cnt_b, ev_b, ea_b, ei_b, ew_b);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_read;
    issue(32'h1020_3C00, 9'h004, 1'b1, 1'b0);
    checks += 3;
    if (cnt_a !== 4'd1) begin errors++; $display("FAIL read_cnt_a got=%0d exp=1", cnt_a); end
    if (cnt_b !== 16'd1) begin errors++; $display("FAIL read_cnt_b got=%0d exp=1", cnt_b); end
    if ({ev_a, ea_a, ei_a, ew_a} !== exp_cap(1'b1, 32'h1020_3C00, 9'h004, 1'b0)) begin
      errors++; $display("FAIL read_cap got=%h exp=%h", {ev_a, ea_a, ei_a, ew_a}, exp_cap(1'b1, 32'h1020_3C00, 9'h004, 1'b0));
    end
    idle(4);
  endtask

  task automatic test_back_to_back;
    pulse_clr();
    checks += 2;
    if ({cnt_a, cnt_b} !== '0) begin errors++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); end
    if ({ev_b, ea_b, ei_b, ew_b} !== '0) begin errors++; $display("FAIL clr_cap got=%h exp=0", {ev_b, ea_b, ei_b, ew_b}); end
    issue(32'h1020_0000, 9'h001, 1'b0, 1'b0);
    issue(32'h1030_0400, 9'h002, 1'b1, 1'b0);
    issue(32'h1000_0010, 9'h004, 1'b0, 1'b0);
    issue(32'h1040_0000, 9'h100, 1'b1, 1'b0);
    checks += 3;
    if (cnt_a !== 4'd4) begin errors++; $display("FAIL b2b_cnt_a got=%0d exp=4", cnt_a); end
    if (cnt_b !== 16'd4) begin errors++; $display("FAIL b2b_cnt_b got=%0d exp=4", cnt_b); end
    if ({ev_b, ea_b, ei_b, ew_b} !== exp_cap(1'b1, 32'h1020_0000, 9'h001, 1'b1)) begin
      errors++; $display("FAIL first_fault_cap got=%h exp=%h", {ev_b, ea_b, ei_b, ew_b}, exp_cap(1'b1, 32'h1020_0000, 9'h001, 1'b1));
    end
    idle(5);
  endtask

  task automatic test_capture;
    pulse_clr();
    issue(32'h1A00_0000, 9'h080, 1'b1, 1'b0);
    checks++;
    if ({ev_a, ea_a, ei_a, ew_a} !== exp_cap(1'b1, 32'h1A00_0000, 9'h080, 1'b0)) begin
      errors++; $display("FAIL recap_after_clr got=%h exp=%h", {ev_a, ea_a, ei_a, ew_a}, exp_cap(1'b1, 32'h1A00_0000, 9'h080, 1'b0));
    end
    issue(32'h1B00_0000, 9'h010, 1'b0, 1'b0);
    checks++;
    if ({ev_a, ea_a, ei_a, ew_a} !== exp_cap(1'b1, 32'h1A00_0000, 9'h080, 1'b0)) begin
      errors++; $display("FAIL cap_hold got=%h exp=%h", {ev_a, ea_a, ei_a, ew_a}, exp_cap(1'b1, 32'h1A00_0000, 9'h080, 1'b0));
    end
    issue(32'h1C00_0000, 9'h020, 1'b0, 1'b1);
    checks += 3;
    if ({ev_b, ea_b, ei_b, ew_b} !== exp_cap(1'b1, 32'h1C00_0000, 9'h020, 1'b1)) begin
      errors++; $display("FAIL cap_clr_req got=%h exp=%h", {ev_b, ea_b, ei_b, ew_b}, exp_cap(1'b1, 32'h1C00_0000, 9'h020, 1'b1));
    end
    if (cnt_a !== 4'd1) begin errors++; $display("FAIL clr_req_cnt_a got=%0d exp=1", cnt_a); end
    if (cnt_b !== 16'd1) begin errors++; $display("FAIL clr_req_cnt_b got=%0d exp=1", cnt_b); end
    idle(4);
  endtask

  task automatic test_saturate;
    pulse_clr();
    for (int i = 0; i < 20; i++) issue(32'h1000_0000 + 32'(i * 4), 9'(1 << (i % 9)), 1'(i % 2), 1'b0);
    checks += 2;
    if (cnt_a !== 4'd15) begin errors++; $display("FAIL sat_cnt_a got=%0d exp=15", cnt_a); end
    if (cnt_b !== 16'd20) begin errors++; $display("FAIL sat_cnt_b got=%0d exp=20", cnt_b); end
    issue(32'h1D00_0000, 9'h040, 1'b1, 1'b1);
    checks += 2;
    if (cnt_a !== 4'd1) begin errors++; $display("FAIL sat_clr_cnt_a got=%0d exp=1", cnt_a); end
    if (cnt_b !== 16'd1) begin errors++; $display("FAIL sat_clr_cnt_b got=%0d exp=1", cnt_b); end
    idle(4);
  endtask

  task automatic test_reset_midflight;
    issue(32'h1E00_0000, 9'h008, 1'b1, 1'b0);
    rst_n = 1'b0;
    sb_a.delete();
    sb_b.delete();
    #1;
    checks += 2;
    if ({rv_a, opc_a, rid_a, rdata_a, cnt_a, ev_a, ea_a, ei_a, ew_a} !== '0) begin
      errors++; $display("FAIL midrst_a got=%b %h %h %h exp=all0", rv_a, rid_a, rdata_a, cnt_a);
    end
    if ({rv_b, opc_b, rid_b, rdata_b, cnt_b, ev_b, ea_b, ei_b, ew_b} !== '0) begin
      errors++; $display("FAIL midrst_b got=%b %h %h %h exp=all0", rv_b, rid_b, rdata_b, cnt_b);
    end
    idle(2);
    rst_n = 1'b1;
    idle(6);
    checks++;
    if ({cnt_a, cnt_b} !== '0) begin errors++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_capture();
    test_saturate();
    test_reset_midflight();
    idle(2);
    checks++;
    if ((sb_a.size() + sb_b.size()) != 0) begin
      errors++; $display("FAIL pending_rsp got=%0d exp=0", sb_a.size() + sb_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_error_slave.md
# periph_error_slave

Sink for peripheral-crossbar requests that decode to the error port (unmapped cluster peripheral addresses, absent HWPE, direct external-port aliases). Accepts every request in the cycle it is presented and returns an error response (`r_opc_o`=1, fixed poison data) a configurable number of cycles later, preserving the requester ID. Optionally captures the first faulting access for software diagnosis. Sits on the crossbar's error master port, in place of a real peripheral.

## Interface
- `ADDR_WIDTH`, 32, request address width
- `DATA_WIDTH`, 32, data width
- `BE_WIDTH`, 4, byte-enable width
- `ID_WIDTH`, 9, one-hot requester ID width (cores + master peripherals)
- `RESP_LATENCY`, 1, cycles from grant to `r_valid_o`; legal range 1..8
- `ERR_RDATA`, 32'hBADACCE5, value driven on `r_rdata_o` with every response
- `CNT_WIDTH`, 16, width of the error counter

Ports:
- `clk_i` in 1 clock
- `rst_ni` in 1 asynchronous active-low reset
- `req_i` in 1 request valid
- `add_i` in ADDR_WIDTH request address
- `wen_i` in 1 write enable, active low (0 = write)
- `wdata_i` in DATA_WIDTH write data (ignored)
- `be_i` in BE_WIDTH byte enables (ignored)
- `id_i` in ID_WIDTH requester ID
- `gnt_o` out 1 grant
- `r_valid_o` out 1 response valid
- `r_opc_o` out 1 response error flag
- `r_id_o` out ID_WIDTH response ID
- `r_rdata_o` out DATA_WIDTH response data
- `clr_i` in 1 clear counter and capture, synchronous pulse
- `err_count_o` out CNT_WIDTH saturating count of accepted requests
- `err_valid_o` out 1 capture register holds an access (only with the macro)
- `err_addr_o` out ADDR_WIDTH captured address (only with the macro)
- `err_id_o` out ID_WIDTH captured ID (only with the macro)
- `err_we_o` out 1 captured access was a write (active high, only with the macro)

## Operation
- `gnt_o` = `req_i`, combinational. Every request is accepted the cycle it is presented; there is no back-pressure.
- Response delay line: RESP_LATENCY stages, each holding {valid, id}. Stage 0 loads {`req_i`, `id_i`} every cycle, and each stage shifts one per cycle. `r_valid_o` and `r_id_o` come from the last stage.
- `r_opc_o` = `r_valid_o`. `r_rdata_o` = ERR_RDATA when `r_valid_o` is high, else 0.
- Reads and writes both get exactly one response. Back-to-back requests give back-to-back responses in order, one per cycle. A response slot never collides with another.
- Counter: increments by 1 per accepted request and saturates at 2^CNT_WIDTH−1. If `clr_i` and an accepted request fall in the same cycle, the counter becomes 1.
- No state machine beyond the delay line, the counter and the capture register. The arbitration upstream guarantees at most one request per cycle.

## Timing
- Reset (async assert, sync release): all delay-line stages are invalid. `r_valid_o`=0, `r_opc_o`=0, `r_id_o`=0, `r_rdata_o`=0, `err_count_o`=0, `err_valid_o`=0, `err_addr_o`=0, `err_id_o`=0, `err_we_o`=0.
- Request granted in cycle T gives `r_valid_o` in cycle T+RESP_LATENCY, for exactly one cycle.
- Asserting reset mid-operation drops all in-flight responses. No response is emitted after reset release for requests granted before it.
- `err_count_o` and the capture outputs update in cycle T+1 for a grant in cycle T.
- `r_ready` is implicit and always 1. A response is never stalled.

## Configuration
- `PERIPH_ERR_CAPTURE_EN` defined:
  - On an accepted request while `err_valid_o`=0, the block latches `add_i`, `id_i` and `~wen_i`, and sets `err_valid_o`.
  - Later errors do not overwrite the capture until `clr_i`.
  - If `clr_i` and an accepted request fall in the same cycle, the new request is captured and `err_valid_o` stays 1.
- Not defined: the capture registers are not built, and the four capture outputs are tied to 0. Responses and the counter are unaffected.

## Test plan
- RESP_LATENCY=1, read: `add_i`=0x1020_3C00, `id_i`=9'h004, `wen_i`=1 at T. Expect `gnt_o`=1 at T, then at T+1 `r_valid_o`=1, `r_opc_o`=1, `r_id_o`=9'h004, `r_rdata_o`=0xBADACCE5, and `err_count_o`=1.
- RESP_LATENCY=3, four back-to-back requests with IDs 0x001, 0x002, 0x004, 0x100 (mixed read/write). Expect responses at T+3..T+6 in the same ID order, with `r_valid_o` continuously high for 4 cycles.
- CNT_WIDTH=4, 20 requests. Expect `err_count_o` to saturate at 15. Then `clr_i` pulsed together with one request gives `err_count_o`=1.
- Capture (macro on), write: 0x1020_0000 from ID 0x001, then read 0x1030_0400 from ID 0x002. Expect capture = {0x1020_0000, 0x001, we=1}. After `clr_i`, the next request from ID 0x080 is captured.
- Reset asserted one cycle after a grant with RESP_LATENCY=2. Expect all outputs 0 immediately and no `r_valid_o` after release.
- Macro off: any request pattern gives `err_valid_o`/`err_addr_o`/`err_id_o`/`err_we_o` = 0, while responses are identical to the macro-on build.
